// File: rtl/aes_encipher_block_px.sv
// AES encipher round engine for 128/192/256-bit keys with 1, 2 or 4 parallel S-box lanes.
// Optional feature: define AES_ENC_ABORT_EN to add an 'abort' input that returns the
// engine to idle at the next edge, leaving new_block and round untouched.
module aes_encipher_block_px #(
    parameter int unsigned NUM_SBOX = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
`ifdef AES_ENC_ABORT_EN
    input  logic                     abort,
`endif
    input  logic                     next,
    input  logic [1:0]               keylen,
    output logic [3:0]               round,
    input  logic [127:0]             round_key,
    output logic [32*NUM_SBOX-1:0]   sboxw,
    input  logic [32*NUM_SBOX-1:0]   new_sboxw,
    input  logic [127:0]             block,
    output logic [127:0]             new_block,
    output logic                     ready
);

    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
        $error("aes_encipher_block_px: NUM_SBOX must be 1, 2 or 4");
    end

    // Cycles spent in SBOX per round; guarded so an illegal value fails only on the check above.
    localparam int unsigned SboxCycles = (NUM_SBOX == 0) ? 1 : 4 / NUM_SBOX;
    localparam logic [1:0]  SwordLast  = 2'(SboxCycles - 1);

    typedef enum logic [1:0] {StIdle, StInit, StSbox, StMain} state_e;

    state_e       state_q, state_d;
    logic [3:0]   round_ctr_q, round_ctr_d;
    logic [1:0]   sword_ctr_q, sword_ctr_d;
    logic [1:0]   keylen_q, keylen_d;
    logic         ready_q, ready_d;
    logic [127:0] block_q, block_d;

    logic [127:0] sub_block;
    logic [3:0]   nr;
    int           widx;

    // GF(2^8) multiply by 2.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    // One MixColumns column: rows {2,3,1,1} rotated per output byte.
    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte (row r, column c) lives at index 4c+r counted from the MSB; row r rotates left by r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = mix_word(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    assign nr = (keylen_q == 2'b01) ? 4'd12 :
                (keylen_q == 2'b10) ? 4'd14 : 4'd10;

    // S-box lane routing: present this cycle's words and splice the substituted words back in.
    always_comb begin
        sboxw     = '0;
        sub_block = block_q;
        widx      = 0;
        if (state_q == StSbox) begin
            for (int j = 0; j < int'(NUM_SBOX); j++) begin
                widx = int'(sword_ctr_q) * int'(NUM_SBOX) + j;
                sboxw[32*j +: 32] = block_q[127 - 32*widx -: 32];
                sub_block[127 - 32*widx -: 32] = new_sboxw[32*j +: 32];
            end
        end
    end

    // Next-state logic for the round FSM and the block datapath.
    always_comb begin
        state_d     = state_q;
        round_ctr_d = round_ctr_q;
        sword_ctr_d = sword_ctr_q;
        keylen_d    = keylen_q;
        ready_d     = ready_q;
        block_d     = block_q;

        case (state_q)
            StIdle: begin
                if (next) begin
                    round_ctr_d = 4'd0;
                    ready_d     = 1'b0;
                    keylen_d    = keylen;
                    state_d     = StInit;
                end
            end
            StInit: begin
                block_d     = block ^ round_key;
                round_ctr_d = 4'd1;
                sword_ctr_d = 2'd0;
                state_d     = StSbox;
            end
            StSbox: begin
                block_d     = sub_block;
                sword_ctr_d = sword_ctr_q + 2'd1;
                if (sword_ctr_q == SwordLast) begin
                    state_d = StMain;
                end
            end
            StMain: begin
                round_ctr_d = round_ctr_q + 4'd1;
                if (round_ctr_q < nr) begin
                    block_d     = mix_columns(shift_rows(block_q)) ^ round_key;
                    sword_ctr_d = 2'd0;
                    state_d     = StSbox;
                end else begin
                    block_d = shift_rows(block_q) ^ round_key;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef AES_ENC_ABORT_EN
        // Abort wins over everything, including a start and the final-round update.
        if (abort) begin
            state_d     = StIdle;
            ready_d     = 1'b1;
            round_ctr_d = round_ctr_q;
            sword_ctr_d = 2'd0;
            keylen_d    = keylen_q;
            block_d     = block_q;
        end
`endif
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            round_ctr_q <= 4'd0;
            sword_ctr_q <= 2'd0;
            keylen_q    <= 2'b00;
            ready_q     <= 1'b1;
            block_q     <= '0;
        end else begin
            state_q     <= state_d;
            round_ctr_q <= round_ctr_d;
            sword_ctr_q <= sword_ctr_d;
            keylen_q    <= keylen_d;
            ready_q     <= ready_d;
            block_q     <= block_d;
        end
    end

    assign round     = round_ctr_q;
    assign new_block = block_q;
    assign ready     = ready_q;

endmodule

// File: doc/aes_encipher_block_px.md
# aes_encipher_block_px

Parametrised AES encipher round engine supporting 128/192/256-bit keys, with a configurable number of parallel S-box lanes (1, 2 or 4 words per cycle). It sits between the core control logic, the shared S-box array and the key memory. It performs the initial AddRoundKey, the main rounds (SubBytes, ShiftRows, MixColumns, AddRoundKey) and the final round. Key length is latched at start, so a key-length change mid-block has no effect on the block in flight.

## Interface
- NUM_SBOX, default 1, meaning the number of 32-bit words substituted per SBOX cycle. Legal values are 1, 2 and 4; any other value stops elaboration with an error.
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- next  in  1  start request. Sampled only in IDLE.
- keylen  in  2  key length: 00 = 128, 01 = 192, 10 = 256, 11 = 128. Latched when next is accepted.
- round  out  4  current round counter. It drives the round_key lookup.
- round_key  in  128  round key for the current `round`. Must be valid in the same cycle (combinational lookup).
- sboxw  out  32*NUM_SBOX  words to the S-box. Lane j is bits [32j+31:32j].
- new_sboxw  in  32*NUM_SBOX  substituted words, lane-aligned with sboxw. Combinational return.
- block  in  128  plaintext. Word w0 = [127:96].
- new_block  out  128  block state / ciphertext.
- ready  out  1  high when idle and the result is valid.

## Operation
- Nr is 10, 12 or 14 for 128, 192 and 256-bit keys. S = 4/NUM_SBOX.
- States: IDLE, INIT, SBOX, MAIN.
- IDLE, next=1:
  - round_ctr <= 0, ready <= 0, keylen latched.
  - Go to INIT.
- INIT:
  - state <= block ^ round_key.
  - round_ctr <= 1, sword_ctr <= 0.
  - Go to SBOX.
- SBOX:
  - Lane j presents word sword_ctr*NUM_SBOX+j. Those words are replaced with new_sboxw.
  - sword_ctr increments each cycle. After S cycles, go to MAIN.
- MAIN, round_ctr < Nr:
  - state <= MixColumns(ShiftRows(state)) ^ round_key.
  - round_ctr++, sword_ctr <= 0.
  - Go to SBOX.
- MAIN, round_ctr == Nr:
  - state <= ShiftRows(state) ^ round_key (final round).
  - ready <= 1, round_ctr++.
  - Go to IDLE.
- sboxw is 0 outside SBOX.
- new_block holds its value in IDLE until the next INIT.
- GF arithmetic: xtime(b) = {b[6:0],0} ^ (0x1b & {8{b[7]}}). MixColumns uses rows {2,3,1,1}, rotated per output byte.
- Boundary conditions:
  - next while busy: ignored.
  - next in the cycle ready rises: ignored, because the FSM is still in MAIN.
  - keylen change while busy: ignored.
  - reset mid-operation: all registers return to reset values immediately.

## Timing
- Reset values:
  - ready = 1, round = 0, new_block = 0, sboxw = 0.
  - FSM in IDLE, sword_ctr = 0.
- ready falls on the edge that accepts next (edge 0). INIT executes at edge 1.
- ready rises at edge 1 + Nr*(S+1).
- Latency examples:
  - NUM_SBOX=1: 128-bit = 51, 192-bit = 61, 256-bit = 71.
  - NUM_SBOX=4: 128-bit = 21, 192-bit = 25, 256-bit = 29.
- round_key and new_sboxw are consumed combinationally in the same cycle as round and sboxw.
- A new next may be asserted in the first cycle ready is high.

## Configuration
- AES_ENC_ABORT_EN defined:
  - Adds input port `abort` (1 bit).
  - abort=1 in any state forces IDLE and ready=1 at the next edge.
  - new_block and round hold their values; no update_type is applied that cycle.
  - abort has priority over next and over the final-round update.
- Undefined: no abort port. Behaviour is exactly as above.

## Test plan
- FIPS-197 C.1, NUM_SBOX=1, keylen=00:
  - Stimulus: key 000102…0f, pt 00112233445566778899aabbccddeeff.
  - Response: new_block 69c4e0d86a7b0430d8cdb78070b4c55a; ready rises at edge 51.
- C.2, keylen=01:
  - Stimulus: key 000102…17, same pt.
  - Response: dda97ca4864cdfe06eaf70a0ec0d7191; ready at edge 61.
- C.3, NUM_SBOX=4, keylen=10:
  - Stimulus: key 000102…1f, same pt.
  - Response: 8ea2b7ca516745bfeafc49904b496089; ready at edge 29.
- Busy-time changes, 128-bit start:
  - Stimulus: pulse next and change keylen to 10 at edge 10.
  - Response: the result is still the C.1 ciphertext at edge 51; no restart occurs.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 at edge 20.
  - Response: ready=1, round=0, new_block=0 immediately. A subsequent C.1 run passes.
- With AES_ENC_ABORT_EN:
  - Stimulus: abort at edge 15 of a C.1 run.
  - Response: ready=1 at edge 16 and round holds its value. A restart then gives 69c4e0d8… at edge 51 of the new run.
